// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle control unit.
// Holds state codes, opcode values, ALUOp codes and datapath select codes.
// Latency: n/a (types and constants only). Backpressure: n/a.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEM_ADDR = 4'h2,
    S_MEM_RD   = 4'h3,
    S_MEM_WB   = 4'h4,
    S_MEM_WR   = 4'h5,
    S_R_EXEC   = 4'h6,
    S_R_WB     = 4'h7,
    S_BRANCH   = 4'h8,
    S_JUMP     = 4'h9,
    S_I_EXEC   = 4'hA,
    S_I_WB     = 4'hB,
    S_HALT     = 4'hF
  } state_t;

  // Opcodes (IReg[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // ALUOp codes; RTYPE defers to the funct field in the datapath
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_RTYPE = 4'hF;

  // PCSource selects
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // States that own the memory bus and therefore honour mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// mc_perf_counters: free-running cycle and retired-instruction counters.
// Latency: counts are visible the cycle after the enabling event.
// Backpressure: none; both counters wrap silently modulo 2^CNT_W.
// Ports: clk, reset (async high), cycle_en, retire -> cycle_count, instr_count.
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cycle_en,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (cycle_en) cycle_count <= cycle_count + 1'b1;
      if (retire)   instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS-subset control unit with variable-latency memory.
// Latency: zero-wait R/I-type 4, lw 5, sw 4, branch/jump 3 cycles.
// Backpressure: memory states hold until mem_ready; MAX_WAIT misses -> HALT + bus_error.
// Ports: clk, reset, opcode, zero, mem_ready -> datapath controls (Moore, zero
// default), state, halted, sticky bus_error/illegal_op, cycle/instr counters.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             BranchType,
  output logic             LUI,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUOp,
  output logic [3:0]       state,
  output logic             halted,
  output logic             bus_error,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_t            cur_state;
  state_t            nxt_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              wait_last;
  logic              timeout;
  logic              bad_op;
  logic              retire;

  assign state = cur_state;

  // This miss would be the MAX_WAIT-th consecutive one; mem_ready in the
  // same cycle still completes the access.
  assign wait_last = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // Counter only runs while a memory state is stalled; any completion,
  // timeout or non-memory state clears it, so every entry starts at zero.
  assign wait_nxt = (is_mem_state(cur_state) && !mem_ready && !timeout)
                    ? wait_cnt + 1'b1 : '0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_error  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      if (timeout) bus_error  <= 1'b1;
      if (bad_op)  illegal_op <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = cur_state;
    timeout   = 1'b0;
    bad_op    = 1'b0;
    retire    = 1'b0;
    unique case (cur_state)
      S_FETCH: begin
        if (mem_ready)      nxt_state = S_DECODE;
        else if (wait_last) timeout   = 1'b1;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:                        nxt_state = S_R_EXEC;
          OP_LW, OP_SW:                    nxt_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                  nxt_state = S_BRANCH;
          OP_J:                            nxt_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nxt_state = S_I_EXEC;
          OP_HALT: begin
            nxt_state = S_HALT;
            retire    = 1'b1;
          end
          default: begin
            nxt_state = S_HALT;
            bad_op    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: nxt_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)      nxt_state = S_MEM_WB;
        else if (wait_last) timeout   = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          nxt_state = S_FETCH;
          retire    = 1'b1;
        end else if (wait_last) begin
          timeout = 1'b1;
        end
      end
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
        nxt_state = S_FETCH;
        retire    = 1'b1;
      end
      S_R_EXEC: nxt_state = S_R_WB;
      S_I_EXEC: nxt_state = S_I_WB;
      S_HALT:   nxt_state = S_HALT;
      default:  nxt_state = S_FETCH;
    endcase
    if (timeout) nxt_state = S_HALT;
  end

  // Output decode (Moore, except the FETCH ready-qualified writes and the
  // zero-qualified branch PC write)
  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    BranchType = 1'b0;
    LUI        = 1'b0;
    PCSource   = PCS_ALU;
    ALUSrcB    = SRCB_B;
    ALUOp      = ALU_ADD;
    halted     = 1'b0;
    unique case (cur_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_RTYPE;
      end
      S_R_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        // opcode[0] separates bne (taken on !zero) from beq
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        PCSource   = PCS_ALUOUT;
        BranchType = opcode[0];
        PCWrite    = zero ^ opcode[0];
      end
      S_JUMP: begin
        PCSource = PCS_JUMP;
        PCWrite  = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        LUI     = (opcode == OP_LUI);
        if (opcode == OP_ANDI)                         ALUOp = ALU_AND;
        else if (opcode == OP_ORI || opcode == OP_LUI) ALUOp = ALU_OR;
        else                                           ALUOp = ALU_ADD;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        LUI      = (opcode == OP_LUI);
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .reset       (reset),
    .cycle_en    (cur_state != S_HALT),
    .retire      (retire),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed scoreboard bench for mc_control_fsm.
// Stimulus pushes hand-computed per-cycle expectations; a negedge monitor pops and compares.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic        ALUSrcA, RegWrite, BranchType, LUI;
  logic [1:0]  PCSource, ALUSrcB;
  logic [3:0]  ALUOp, state;
  logic        halted, bus_error, illegal_op;
  logic [31:0] cycle_count, instr_count;

  mc_control_fsm #(.CNT_W(32), .MAX_WAIT(15), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .BranchType(BranchType), .LUI(LUI), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .halted(halted), .bus_error(bus_error),
    .illegal_op(illegal_op), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Control vector: [18] check-enable, then
  // PCWrite IorD MemRead MemWrite IRWrite MemtoReg ALUSrcA RegWrite BranchType LUI,
  // PCSource, ALUSrcB, ALUOp
  localparam logic [18:0] NC      = 19'h0;
  localparam logic [18:0] FW      = {1'b1, 10'b0010000000, 2'b00, 2'b01, 4'h0};
  localparam logic [18:0] FG      = {1'b1, 10'b1010100000, 2'b00, 2'b01, 4'h0};
  localparam logic [18:0] DEC     = {1'b1, 10'b0000000000, 2'b00, 2'b11, 4'h0};
  localparam logic [18:0] MA      = {1'b1, 10'b0000001000, 2'b00, 2'b10, 4'h0};
  localparam logic [18:0] MRD     = {1'b1, 10'b0110000000, 2'b00, 2'b00, 4'h0};
  localparam logic [18:0] MWB     = {1'b1, 10'b0000010100, 2'b00, 2'b00, 4'h0};
  localparam logic [18:0] MWR     = {1'b1, 10'b0101000000, 2'b00, 2'b00, 4'h0};
  localparam logic [18:0] REX     = {1'b1, 10'b0000001000, 2'b00, 2'b00, 4'hF};
  localparam logic [18:0] RWB     = {1'b1, 10'b0000000100, 2'b00, 2'b00, 4'h0};
  localparam logic [18:0] BEQ_T   = {1'b1, 10'b1000001000, 2'b01, 2'b00, 4'h1};
  localparam logic [18:0] BNE_NT  = {1'b1, 10'b0000001010, 2'b01, 2'b00, 4'h1};
  localparam logic [18:0] BNE_T   = {1'b1, 10'b1000001010, 2'b01, 2'b00, 4'h1};
  localparam logic [18:0] JMP     = {1'b1, 10'b1000000000, 2'b10, 2'b00, 4'h0};
  localparam logic [18:0] LUI_EX  = {1'b1, 10'b0000001001, 2'b00, 2'b10, 4'h3};
  localparam logic [18:0] LUI_WB  = {1'b1, 10'b0000000101, 2'b00, 2'b00, 4'h0};
  localparam logic [18:0] ANDI_EX = {1'b1, 10'b0000001000, 2'b00, 2'b10, 4'h2};
  localparam logic [18:0] HLT     = {1'b1, 10'b0000000000, 2'b00, 2'b00, 4'h0};

  logic [17:0] act_ctl;
  assign act_ctl = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                    RegWrite, BranchType, LUI, PCSource, ALUSrcB, ALUOp};

  typedef struct {
    string       nm;
    logic [3:0]  st;
    logic [18:0] ctl;
    logic [2:0]  flg;   // {halted, bus_error, illegal_op}
    int          cyc;   // -1 = not checked
    int          ins;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [2:0] exp_flags = 3'b000;

  // Describe the current cycle (inputs already driven), then advance one clock.
  task automatic step(input string nm, input logic [3:0] st, input logic [18:0] ctl,
                      input int cyc = -1, input int ins = -1);
    exp_t e;
    e.nm  = nm;
    e.st  = st;
    e.ctl = ctl;
    e.flg = exp_flags;
    e.cyc = cyc;
    e.ins = ins;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_flags = 3'b000;
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL %s state: got %h want %h", e.nm, state, e.st);
        end
        if (e.ctl[18]) begin
          checks++;
          if (act_ctl !== e.ctl[17:0]) begin
            errors++;
            $display("FAIL %s ctrl: got %b want %b", e.nm, act_ctl, e.ctl[17:0]);
          end
        end
        checks++;
        if ({halted, bus_error, illegal_op} !== e.flg) begin
          errors++;
          $display("FAIL %s flags(h,be,io): got %b want %b", e.nm,
                   {halted, bus_error, illegal_op}, e.flg);
        end
        if (e.cyc >= 0) begin
          checks++;
          if (cycle_count !== e.cyc[31:0]) begin
            errors++;
            $display("FAIL %s cycle_count: got %0d want %0d", e.nm, cycle_count, e.cyc);
          end
        end
        if (e.ins >= 0) begin
          checks++;
          if (instr_count !== e.ins[31:0]) begin
            errors++;
            $display("FAIL %s instr_count: got %0d want %0d", e.nm, instr_count, e.ins);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, then reset asserted in the middle of an lw read stall
    opcode = 6'h23; mem_ready = 1'b0;
    step("rst_state", 4'h0, FW, 0, 0);
    mem_ready = 1'b1; step("rl_fetch", 4'h0, FG);
    mem_ready = 1'b0;
    step("rl_dec", 4'h1, DEC);
    step("rl_addr", 4'h2, MA);
    step("rl_rd1", 4'h3, MRD);
    step("rl_rd2", 4'h3, MRD);
    step("rl_rd3", 4'h3, MRD, 6, 0);
    reset = 1'b1;
    step("in_rst", 4'h0, FW, 0, 0);
    reset = 1'b0;
    step("post_rst", 4'h0, FW, 0, 0);

    // Zero-wait program: add, lw, sw, beq (taken), j
    do_reset();
    mem_ready = 1'b1; zero = 1'b0;
    opcode = 6'h00;
    step("add_f", 4'h0, FG, 0, 0); step("add_d", 4'h1, DEC);
    step("add_x", 4'h6, REX);      step("add_w", 4'h7, RWB);
    opcode = 6'h23;
    step("lw_f", 4'h0, FG, 4, 1);  step("lw_d", 4'h1, DEC); step("lw_a", 4'h2, MA);
    step("lw_r", 4'h3, MRD);       step("lw_w", 4'h4, MWB);
    opcode = 6'h2B;
    step("sw_f", 4'h0, FG, 9, 2);  step("sw_d", 4'h1, DEC); step("sw_a", 4'h2, MA);
    step("sw_w", 4'h5, MWR);
    opcode = 6'h04; zero = 1'b1;
    step("beq_f", 4'h0, FG, 13, 3); step("beq_d", 4'h1, DEC); step("beq_b", 4'h8, BEQ_T);
    opcode = 6'h02; zero = 1'b0;
    step("j_f", 4'h0, FG, 16, 4);  step("j_d", 4'h1, DEC);  step("j_j", 4'h9, JMP);
    mem_ready = 1'b0;
    step("prog_end", 4'h0, FW, 19, 5);

    // bne not taken (zero=1) then taken (zero=0)
    do_reset();
    opcode = 6'h05; mem_ready = 1'b1; zero = 1'b1;
    step("bne1_f", 4'h0, FG, 0, 0); step("bne1_d", 4'h1, DEC); step("bne1_b", 4'h8, BNE_NT);
    zero = 1'b0;
    step("bne2_f", 4'h0, FG, 3, 1); step("bne2_d", 4'h1, DEC); step("bne2_b", 4'h8, BNE_T);
    mem_ready = 1'b0;
    step("bne_end", 4'h0, FW, 6, 2);

    // FETCH stalls 3 cycles; IRWrite/PCWrite only on the 4th; then lui, andi
    do_reset();
    opcode = 6'h0F; mem_ready = 1'b0;
    step("fw1", 4'h0, FW, 0, 0); step("fw2", 4'h0, FW); step("fw3", 4'h0, FW);
    mem_ready = 1'b1;
    step("fw4_go", 4'h0, FG);
    step("lui_d", 4'h1, DEC); step("lui_x", 4'hA, LUI_EX); step("lui_w", 4'hB, LUI_WB);
    opcode = 6'h0C;
    step("andi_f", 4'h0, FG, 7, 1); step("andi_d", 4'h1, DEC);
    step("andi_x", 4'hA, ANDI_EX);  step("andi_w", 4'hB, RWB);
    mem_ready = 1'b0;
    step("andi_end", 4'h0, FW, 11, 2);

    // sw with memory never ready: 15 stalled MEM_WR cycles, then bus error
    do_reset();
    opcode = 6'h2B; mem_ready = 1'b1;
    step("to_f", 4'h0, FG, 0, 0); step("to_d", 4'h1, DEC); step("to_a", 4'h2, MA);
    mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) step($sformatf("to_wr%0d", i), 4'h5, MWR);
    exp_flags = 3'b110;
    step("to_halt", 4'hF, HLT, 18, 0);
    mem_ready = 1'b1;
    step("to_frozen", 4'hF, HLT, 18, 0);

    // Same, but mem_ready arrives on the 15th stall cycle: completes cleanly
    do_reset();
    opcode = 6'h2B; mem_ready = 1'b1;
    step("ok_f", 4'h0, FG, 0, 0); step("ok_d", 4'h1, DEC); step("ok_a", 4'h2, MA);
    mem_ready = 1'b0;
    for (int i = 1; i <= 14; i++) step($sformatf("ok_wr%0d", i), 4'h5, NC);
    mem_ready = 1'b1;
    step("ok_wr15", 4'h5, MWR);
    step("ok_done", 4'h0, FG, 18, 1);

    // HALT opcode retires; illegal opcode does not
    do_reset();
    opcode = 6'h3F; mem_ready = 1'b1;
    step("h_f", 4'h0, FG, 0, 0); step("h_d", 4'h1, DEC);
    exp_flags = 3'b100;
    step("h_halt", 4'hF, HLT, 2, 1);
    step("h_stay", 4'hF, HLT, 2, 1);

    do_reset();
    opcode = 6'h3E; mem_ready = 1'b1;
    step("il_f", 4'h0, FG, 0, 0); step("il_d", 4'h1, DEC);
    exp_flags = 3'b101;
    step("il_halt", 4'hF, HLT, 2, 0);
    step("il_stay", 4'hF, HLT, 2, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
